count_sched: RTL

COUNT_SCHED -- requirements
Module: count_sched

---
 rtl/count_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/count_sched.sv
// Two-requester round-robin scheduler driving a shared, non-wrapping counter.
// Each grant runs the counter from 0 up to the winner's sampled length.
module count_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] count,
    output logic             t,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] len_q, len_n;
    logic             owner, owner_n;
    logic             last, last_n;
    logic [1:0]       gnt_n, done_n;
    logic [WIDTH-1:0] count_n;
    logic             t_n, busy_n;
    logic             win;

    // last == 1 means requester 1 was served most recently
    assign win = (req == 2'b11) ? ~last : req[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len_q <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
            gnt   <= 2'b00;
            count <= '0;
            t     <= 1'b0;
            done  <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            len_q <= len_n;
            owner <= owner_n;
            last  <= last_n;
            gnt   <= gnt_n;
            count <= count_n;
            t     <= t_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len_q;
        owner_n = owner;
        last_n  = last;
        gnt_n   = gnt;
        count_n = count;
        t_n     = 1'b0;
        done_n  = 2'b00;
        case (state)
            IDLE: begin
                gnt_n = 2'b00;
                if (req != 2'b00) begin
                    state_n = RUN;
                    owner_n = win;
                    len_n   = win ? len1 : len0;
                    count_n = '0;
                    gnt_n   = win ? 2'b10 : 2'b01;
                    t_n     = (len_n == '0);
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    gnt_n   = 2'b00;
                    last_n  = owner;
                end else if (t) begin
                    state_n = DONE;
                    gnt_n   = 2'b00;
                    done_n  = owner ? 2'b10 : 2'b01;
                end else begin
                    count_n = count + WIDTH'(1);
                    t_n     = (count_n == len_q);
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
                last_n  = owner;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule
